// File: rtl/id_regfile.sv
// Decode-stage register file: 32x32 with r0 hard-wired to zero, plus retire bookkeeping.
// Define REGFILE_BYPASS_EN to forward the writeback value to the read ports in the same cycle.
module id_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wreg,
  input  logic [4:0]  wb_destR,
  input  logic [31:0] wb_dest,
  input  logic [3:0]  WB_ins_type,
  input  logic [3:0]  WB_ins_number,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic [31:0] id_qa,
  output logic [31:0] id_qb,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] retire_cnt,
  output logic [3:0]  last_ins_number
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [3:0]  last_ins_q, last_ins_d;
  logic        wr_en;
  logic        retire;

  assign wr_en  = wb_wreg && (wb_destR != 5'd0);
  assign retire = (WB_ins_type != 4'h0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wb_destR] = wb_dest;
    end
    regs_d[0] = '0;
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    last_ins_d   = last_ins_q;
    if (retire) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
      last_ins_d   = WB_ins_number;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      retire_cnt_q <= '0;
      last_ins_q   <= '0;
    end else begin
      regs_q       <= regs_d;
      retire_cnt_q <= retire_cnt_d;
      last_ins_q   <= last_ins_d;
    end
  end

  // Address 0 is decoded to zero so reads are clean even before the first reset.
  logic [31:0] stored_a, stored_b;
  assign stored_a = (id_rs == 5'd0) ? 32'd0 : regs_q[id_rs];
  assign stored_b = (id_rt == 5'd0) ? 32'd0 : regs_q[id_rt];
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs_q[dbg_addr];

`ifdef REGFILE_BYPASS_EN
  // Forwarding ignores rst so the read ports track the writeback bus unconditionally.
  assign id_qa = (wr_en && (wb_destR == id_rs)) ? wb_dest : stored_a;
  assign id_qb = (wr_en && (wb_destR == id_rt)) ? wb_dest : stored_b;
`else
  assign id_qa = stored_a;
  assign id_qb = stored_b;
`endif

  assign retire_cnt      = retire_cnt_q;
  assign last_ins_number = last_ins_q;

endmodule

// File: tb/tb_id_regfile.sv
// Self-checking bench for id_regfile: vector table plus scoreboard of expected read data.
module tb_id_regfile;

  logic        clk;
  logic        rst;
  logic        wb_wreg;
  logic [4:0]  wb_destR;
  logic [31:0] wb_dest;
  logic [3:0]  WB_ins_type;
  logic [3:0]  WB_ins_number;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [31:0] id_qa;
  logic [31:0] id_qb;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] retire_cnt;
  logic [3:0]  last_ins_number;

  id_regfile dut (
    .clk             (clk),
    .rst             (rst),
    .wb_wreg         (wb_wreg),
    .wb_destR        (wb_destR),
    .wb_dest         (wb_dest),
    .WB_ins_type     (WB_ins_type),
    .WB_ins_number   (WB_ins_number),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_qa           (id_qa),
    .id_qb           (id_qb),
    .dbg_addr        (dbg_addr),
    .dbg_data        (dbg_data),
    .retire_cnt      (retire_cnt),
    .last_ins_number (last_ins_number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wreg;
    logic [4:0]  dest_r;
    logic [31:0] dest;
    logic [3:0]  typ;
    logic [3:0]  num;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dbg;
    logic [31:0] exp_cnt;
    logic [3:0]  exp_last;
  } vec_t;

  typedef struct {
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] dbg;
  } sb_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] mregs [32];
  sb_t         sb_q [$];
  vec_t        vecs [15];

  function automatic vec_t mk(logic r, logic w, logic [4:0] dr, logic [31:0] d, logic [3:0] t,
                              logic [3:0] n, logic [4:0] a, logic [4:0] b, logic [4:0] g,
                              logic [31:0] ec, logic [3:0] el);
    vec_t v;
    v.rst = r; v.wreg = w; v.dest_r = dr; v.dest = d; v.typ = t; v.num = n;
    v.rs = a; v.rt = b; v.dbg = g; v.exp_cnt = ec; v.exp_last = el;
    return v;
  endfunction

  function automatic logic [31:0] stored(logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : mregs[a];
  endfunction

  function automatic logic [31:0] port_exp(vec_t v, logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    if (v.wreg && v.dest_r != 5'd0 && v.dest_r == a) return v.dest;
`endif
    return stored(a);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive, check combinational reads, clock, check retire state.
  task automatic step(vec_t v);
    sb_t e;
    sb_t g;
    @(negedge clk);
    rst = v.rst; wb_wreg = v.wreg; wb_destR = v.dest_r; wb_dest = v.dest;
    WB_ins_type = v.typ; WB_ins_number = v.num;
    id_rs = v.rs; id_rt = v.rt; dbg_addr = v.dbg;
    e.qa  = port_exp(v, v.rs);
    e.qb  = port_exp(v, v.rt);
    e.dbg = stored(v.dbg);
    sb_q.push_back(e);
    #1;
    g = sb_q.pop_front();
    check("id_qa", id_qa, g.qa);
    check("id_qb", id_qb, g.qb);
    check("dbg_data", dbg_data, g.dbg);
    @(posedge clk);
    if (v.rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = '0;
    end else if (v.wreg && v.dest_r != 5'd0) begin
      mregs[v.dest_r] = v.dest;
    end
    #1;
    check("retire_cnt", retire_cnt, v.exp_cnt);
    check("last_ins_number", {28'd0, last_ins_number}, {28'd0, v.exp_last});
  endtask

  initial begin
    rst = 1'b1; wb_wreg = 1'b0; wb_destR = '0; wb_dest = '0;
    WB_ins_type = '0; WB_ins_number = '0; id_rs = '0; id_rt = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;

    //            rst w  dR  data          typ num rs rt dbg cnt last
    vecs[0]  = mk(1, 0, 0, 32'h0,         0, 0,  0, 0, 0,  0, 0);
    vecs[1]  = mk(0, 1, 5, 32'hDEADBEEF,  1, 3,  5, 5, 5,  1, 3);
    vecs[2]  = mk(0, 0, 0, 32'h0,         0, 0,  5, 5, 5,  1, 3);
    vecs[3]  = mk(1, 1, 6, 32'h00000066,  2, 4,  6, 5, 5,  0, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,         0, 9,  5, 6, 5,  0, 0);
    vecs[5]  = mk(0, 1, 0, 32'h12345678,  0, 0,  0, 0, 0,  0, 0);
    vecs[6]  = mk(0, 0, 0, 32'h0,         0, 0,  0, 0, 0,  0, 0);
    vecs[7]  = mk(0, 0, 0, 32'h0,         1, 1,  0, 0, 0,  1, 1);
    vecs[8]  = mk(0, 1, 9, 32'hCAFE0009,  0, 2,  9, 9, 9,  1, 1);
    vecs[9]  = mk(0, 0, 0, 32'h0,         3, 3,  9, 0, 9,  2, 3);
    vecs[10] = mk(0, 0, 0, 32'h0,         0, 4,  0, 0, 0,  2, 3);
    vecs[11] = mk(0, 0, 0, 32'h0,         2, 5,  0, 0, 0,  3, 5);
    vecs[12] = mk(0, 1, 7, 32'h11111111,  0, 0,  0, 0, 7,  3, 5);
    vecs[13] = mk(0, 1, 7, 32'hA5A5A5A5,  0, 0,  7, 7, 7,  3, 5);
    vecs[14] = mk(0, 0, 0, 32'h0,         0, 0,  7, 7, 7,  3, 5);

    for (int i = 0; i < 15; i++) step(vecs[i]);

    // Same-cycle write to r7: dbg must show the old value in either build.
    @(negedge clk);
    wb_wreg = 1'b1; wb_destR = 5'd7; wb_dest = 32'h5A5A5A5A; id_rs = 5'd7; id_rt = 5'd7;
    dbg_addr = 5'd7; WB_ins_type = 4'h0; rst = 1'b0;
    #1;
    check("dbg_old_r7", dbg_data, 32'hA5A5A5A5);
`ifdef REGFILE_BYPASS_EN
    check("qa_bypass_r7", id_qa, 32'h5A5A5A5A);
`else
    check("qa_stored_r7", id_qa, 32'hA5A5A5A5);
`endif
    @(posedge clk);
    mregs[7] = 32'h5A5A5A5A;
    @(negedge clk);
    wb_wreg = 1'b0;
    #1;
    check("qa_next_r7", id_qa, 32'h5A5A5A5A);

    // Counter wrap via backdoor preload.
    @(negedge clk);
    dut.retire_cnt_q = 32'hFFFFFFFF;
    step(mk(0, 0, 0, 32'h0, 4'h1, 4'hA, 0, 0, 0, 32'd0, 4'hA));

    // Sweep: write r1..r31, then read every register through all three ports.
    for (int i = 1; i < 32; i++) begin
      step(mk(0, 1, 5'(i), 32'(i) * 32'h01010101, 0, 0, 5'(i), 5'(32 - i), 5'(i), 0, 4'hA));
    end
    for (int i = 0; i < 32; i++) begin
      step(mk(0, 0, 0, 32'h0, 0, 0, 5'(i), 5'(31 - i), 5'(i), 0, 4'hA));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_regfile.md
ID_REGFILE -- requirements
Module: id_regfile

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state updates on rising edge) and rst input 1 (synchronous, active-high).
REQ-002 The block SHALL have these ports:
- wb_wreg  input  1  writeback write enable
- wb_destR  input  5  writeback destination register
- wb_dest  input  32  writeback data
- WB_ins_type  input  4  type of instruction in WB; 4'h0 = bubble
- WB_ins_number  input  4  tag of instruction in WB
- id_rs  input  5  read port A address
- id_rt  input  5  read port B address
- id_qa  output  32  read port A data
- id_qb  output  32  read port B data
- dbg_addr  input  5  debug read address
- dbg_data  output  32  debug read data
- retire_cnt  output  32  count of non-bubble instructions retired
- last_ins_number  output  4  WB_ins_number of the most recent retired instruction

Function
REQ-003 The block SHALL hold 32 registers of 32 bits each, and register 0 SHALL always read 0.
REQ-004 On a rising clk edge with rst=0, wb_wreg=1 and wb_destR!=0, the block SHALL write wb_dest into register wb_destR.
- A write with wb_destR=0 SHALL be discarded.
REQ-005 id_qa, id_qb and dbg_data SHALL be combinational reads of the addressed register (zero latency).
REQ-006 Write latency SHALL be one cycle: a written value SHALL be visible from the storage array from the cycle after the write edge.
REQ-007 Both read ports SHALL support the same address, including one equal to wb_destR, in the same cycle. Each port SHALL then return identical data per REQ-003/REQ-014.
REQ-008 On each rising edge with rst=0 and WB_ins_type!=4'h0:
- retire_cnt SHALL increment by 1, wrapping from 32'hFFFFFFFF to 0.
- last_ins_number SHALL load WB_ins_number.
REQ-009 A bubble (WB_ins_type=4'h0) SHALL leave retire_cnt and last_ins_number unchanged. A bubble SHALL still perform a register write if wb_wreg=1.
REQ-010 A register write SHALL NOT depend on WB_ins_type, and retire counting SHALL NOT depend on wb_wreg.
REQ-011 dbg_data SHALL never be bypassed. It SHALL always show stored array contents.

Reset
REQ-012 While rst=1 at a rising edge, the block SHALL:
- clear all 32 registers to 0;
- set retire_cnt to 0;
- set last_ins_number to 4'h0;
- ignore any concurrent write or retire.
REQ-013 Reset asserted mid-program SHALL take effect at the next edge, and the first post-reset edge SHALL behave as normal operation.

Configuration
REQ-014 Macro REGFILE_BYPASS_EN SHALL select write-to-read bypass.
- Defined: when wb_wreg=1, wb_destR!=0 and wb_destR equals id_rs (or id_rt), id_qa (or id_qb) SHALL return wb_dest combinationally in the same cycle. This bypass SHALL apply even while rst=1.
- Not defined: read ports SHALL return only stored contents, and the new value SHALL appear the following cycle.

Verification
REQ-015 Reset: write 32'hDEADBEEF to r5, assert rst one cycle, read r5 -> id_qa=0, retire_cnt=0, last_ins_number=0.
REQ-016 r0 guard: wb_wreg=1, wb_destR=0, wb_dest=32'h12345678, then id_rs=0 -> id_qa=0 with and without the macro.
REQ-017 Bypass: wb_wreg=1, wb_destR=7, wb_dest=32'hA5A5A5A5, id_rs=id_rt=7 in the same cycle. Required response:
- With REGFILE_BYPASS_EN: id_qa=id_qb=32'hA5A5A5A5 that cycle.
- Without it: old r7 that cycle, then 32'hA5A5A5A5 the next cycle.
- In both builds, dbg_data at address 7 SHALL show old r7 that cycle.
REQ-018 Retire: WB_ins_type sequence 1,0,3,0,2 with WB_ins_number 1..5 -> retire_cnt=3 and last_ins_number=5 after five edges.
REQ-019 Wrap: force retire_cnt to 32'hFFFFFFFF via 2^32-1 retires (or a backdoor preload), then one non-bubble -> retire_cnt=0.
REQ-020 Full sweep: write r1..r31 with value (index*32'h01010101), then read all through id_qa, id_qb and dbg_data -> each matches, and r0=0.
